// File: rtl/cv32e41p_register_file_mp_pkg.sv
// Shared constants, types and word-count helper for the multi-port register file.
// Bit FP_BANK_BIT of a register address selects the FP bank when that bank exists.
package cv32e41p_rf_pkg;

    localparam int NUM_INT_WORDS = 32;
    localparam int NUM_FP_WORDS  = 32;
    localparam int FP_BANK_BIT   = 5;

    typedef logic [5:0]  rf_addr_t;
    typedef logic [31:0] rf_data_t;

    function automatic int rf_num_words(input int fpu, input int pulp_zfinx);
        return ((fpu != 0) && (pulp_zfinx == 0)) ? (NUM_INT_WORDS + NUM_FP_WORDS) : NUM_INT_WORDS;
    endfunction

endpackage

// File: rtl/cv32e41p_register_file_mp_if.sv
// Bundle of read, write, reservation and flush signals between the ID/WB stages and the register file.
// master = pipeline side, slave = register file.
interface cv32e41p_register_file_mp_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 3,
    parameter int NUM_WPORTS = 2
) ();

    logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i;
    logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o;
    logic [NUM_RPORTS-1:0]            rbusy_o;
    logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr_i;
    logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_WPORTS-1:0]            we_i;
    logic                             rsv_i;
    logic [ADDR_WIDTH-1:0]            rsv_addr_i;
    logic                             flush_i;
    logic                             busy_any_o;

    modport master (
        output raddr_i, waddr_i, wdata_i, we_i, rsv_i, rsv_addr_i, flush_i,
        input  rdata_o, rbusy_o, busy_any_o
    );

    modport slave (
        input  raddr_i, waddr_i, wdata_i, we_i, rsv_i, rsv_addr_i, flush_i,
        output rdata_o, rbusy_o, busy_any_o
    );

endinterface

// File: rtl/cv32e41p_register_file_mp_scoreboard.sv
// Per-register busy bits for outstanding long-latency writes.
// Priority at the edge: reserve > flush > write-clear > hold; word 0 is never busy.
module cv32e41p_rf_scoreboard #(
    parameter int NUM_WORDS  = 32,
    parameter int IDX_W      = 5,
    parameter int NUM_RPORTS = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rsv_i,
    input  logic [IDX_W-1:0]            rsv_idx_i,
    input  logic                        flush_i,
    input  logic [NUM_WORDS-1:0]        clr_i,
    input  logic [NUM_RPORTS*IDX_W-1:0] ridx_i,
    output logic [NUM_RPORTS-1:0]       rbusy_o,
    output logic                        busy_any_o
);

    logic [NUM_WORDS-1:0] busy_reg;
    logic [NUM_WORDS-1:0] busy_next;

    always_comb begin
        busy_next = busy_reg;
        for (int i = 1; i < NUM_WORDS; i++) begin
            if (rsv_i && (rsv_idx_i == IDX_W'(i))) begin
                busy_next[i] = 1'b1;
            end else if (flush_i || clr_i[i]) begin
                busy_next[i] = 1'b0;
            end
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RPORTS; gi++) begin : g_rbusy
            assign rbusy_o[gi] = busy_reg[ridx_i[gi*IDX_W +: IDX_W]];
        end
    endgenerate

    assign busy_any_o = |busy_reg;

endmodule

// File: rtl/cv32e41p_register_file_mp.sv
// Multi-port flip-flop register file (int bank, optional FP bank) with issue scoreboard.
// Define CV32E41P_RF_BYPASS_EN to forward same-cycle write data (and clear rbusy) onto matching reads.
module cv32e41p_register_file_mp
    import cv32e41p_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 3,
    parameter int NUM_WPORTS = 2,
    parameter int FPU        = 0,
    parameter int PULP_ZFINX = 0
) (
    input logic                          clk,
    input logic                          rst_n,
    cv32e41p_register_file_mp_if.slave   rf
);

    localparam int NUM_WORDS = rf_num_words(FPU, PULP_ZFINX);
    localparam int IDX_W     = $clog2(NUM_WORDS);

    // Without the FP bank only the low bits index storage, so address 32 aliases x0.
    logic [IDX_W-1:0]            widx [NUM_WPORTS];
    logic [IDX_W-1:0]            ridx [NUM_RPORTS];
    logic [NUM_RPORTS*IDX_W-1:0] ridx_flat;
    logic [IDX_W-1:0]            rsv_idx;
    logic                        unused_addr_bits;

    logic [DATA_WIDTH-1:0]       rf_q [NUM_WORDS];
    logic [NUM_WORDS-1:0]        wr_hit;
    logic [NUM_RPORTS-1:0]       sb_rbusy;

    assign rsv_idx          = rf.rsv_addr_i[IDX_W-1:0];
    assign unused_addr_bits = ^{rf.raddr_i, rf.waddr_i, rf.rsv_addr_i};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WPORTS; gi++) begin : g_widx
            assign widx[gi] = rf.waddr_i[gi*ADDR_WIDTH +: IDX_W];
        end

        for (gi = 0; gi < NUM_RPORTS; gi++) begin : g_ridx
            assign ridx[gi]                       = rf.raddr_i[gi*ADDR_WIDTH +: IDX_W];
            assign ridx_flat[gi*IDX_W +: IDX_W]   = ridx[gi];
        end

        assign rf_q[0]   = '0;
        assign wr_hit[0] = 1'b0;

        for (gi = 1; gi < NUM_WORDS; gi++) begin : g_word
            logic [DATA_WIDTH-1:0] word_reg;
            logic [DATA_WIDTH-1:0] word_next;
            logic                  wen;

            // Later ports override earlier ones on an address conflict.
            always_comb begin
                wen       = 1'b0;
                word_next = word_reg;
                for (int p = 0; p < NUM_WPORTS; p++) begin
                    if (rf.we_i[p] && (widx[p] == IDX_W'(gi))) begin
                        wen       = 1'b1;
                        word_next = rf.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (wen) begin
                    word_reg <= word_next;
                end
            end

            assign rf_q[gi]   = word_reg;
            assign wr_hit[gi] = wen;
        end

        for (gi = 0; gi < NUM_RPORTS; gi++) begin : g_rd
            logic [DATA_WIDTH-1:0] rd;
            logic                  fwd;

            always_comb begin
                rd  = rf_q[ridx[gi]];
                fwd = 1'b0;
`ifdef CV32E41P_RF_BYPASS_EN
                for (int p = 0; p < NUM_WPORTS; p++) begin
                    if (rf.we_i[p] && (widx[p] == ridx[gi]) && (ridx[gi] != '0)) begin
                        rd  = rf.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                        fwd = 1'b1;
                    end
                end
`endif
            end

            assign rf.rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = rd;
            assign rf.rbusy_o[gi]                          = sb_rbusy[gi] & ~fwd;
        end
    endgenerate

    cv32e41p_rf_scoreboard #(
        .NUM_WORDS  (NUM_WORDS),
        .IDX_W      (IDX_W),
        .NUM_RPORTS (NUM_RPORTS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .rsv_i      (rf.rsv_i),
        .rsv_idx_i  (rsv_idx),
        .flush_i    (rf.flush_i),
        .clr_i      (wr_hit),
        .ridx_i     (ridx_flat),
        .rbusy_o    (sb_rbusy),
        .busy_any_o (rf.busy_any_o)
    );

endmodule

// File: tb/tb_cv32e41p_register_file_mp.sv
// Bench for cv32e41p_register_file_mp: directed table, hand sequences (reset, bypass, FP bank, ZFINX alias)
// and randomized traffic against an array-based reference model.
module tb_cv32e41p_register_file_mp;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NR = 3;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cv32e41p_register_file_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .NUM_WPORTS(NW)) rf_if ();
    cv32e41p_register_file_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .NUM_WPORTS(NW)) fp_if ();
    cv32e41p_register_file_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .NUM_WPORTS(NW)) zx_if ();

    cv32e41p_register_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .NUM_WPORTS(NW),
                                .FPU(0), .PULP_ZFINX(0)) dut (.clk(clk), .rst_n(rst_n), .rf(rf_if));
    cv32e41p_register_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .NUM_WPORTS(NW),
                                .FPU(1), .PULP_ZFINX(0)) dut_fp (.clk(clk), .rst_n(rst_n), .rf(fp_if));
    cv32e41p_register_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .NUM_WPORTS(NW),
                                .FPU(1), .PULP_ZFINX(1)) dut_zx (.clk(clk), .rst_n(rst_n), .rf(zx_if));

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        we0;
        logic [5:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [5:0]  wa1;
        logic [31:0] wd1;
        logic        rsv;
        logic [5:0]  rsv_a;
        logic        flush;
        logic [5:0]  rd_a;
        logic [31:0] exp_d;
        logic        exp_b;
        logic        exp_any;
    } vec_t;

    vec_t tbl [18];

    logic [31:0] m_reg  [32];
    logic        m_busy [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_main();
        rf_if.we_i    = '0;
        rf_if.rsv_i   = 1'b0;
        rf_if.flush_i = 1'b0;
    endtask

    task automatic drive_w(input int p, input logic [5:0] a, input logic [31:0] d);
        rf_if.waddr_i[p*AW +: AW] = a;
        rf_if.wdata_i[p*DW +: DW] = d;
        rf_if.we_i[p]             = 1'b1;
    endtask

    task automatic set_raddr_all(input logic [5:0] a);
        for (int r = 0; r < NR; r++) rf_if.raddr_i[r*AW +: AW] = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Directed table: inputs applied for one cycle, result read back on the following idle cycle.
        tbl[0]  = '{1'b1, 6'd5,  32'hDEADBEEF, 1'b0, 6'd0,  32'h0,  1'b0, 6'd0,  1'b0, 6'd5,  32'hDEADBEEF, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 6'd0,  32'h1,        1'b0, 6'd0,  32'h0,  1'b0, 6'd0,  1'b0, 6'd0,  32'h0,        1'b0, 1'b0};
        tbl[2]  = '{1'b1, 6'd7,  32'h11,       1'b1, 6'd7,  32'h22, 1'b0, 6'd0,  1'b0, 6'd7,  32'h22,       1'b0, 1'b0};
        tbl[3]  = '{1'b1, 6'd11, 32'hBB,       1'b1, 6'd11, 32'hAA, 1'b0, 6'd0,  1'b0, 6'd11, 32'hAA,       1'b0, 1'b0};
        tbl[4]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,  1'b1, 6'd9,  1'b0, 6'd9,  32'h0,        1'b1, 1'b1};
        tbl[5]  = '{1'b1, 6'd9,  32'h5,        1'b0, 6'd0,  32'h0,  1'b0, 6'd0,  1'b0, 6'd9,  32'h5,        1'b0, 1'b0};
        tbl[6]  = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd9,  32'h6,  1'b1, 6'd9,  1'b0, 6'd9,  32'h6,        1'b1, 1'b1};
        tbl[7]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,  1'b1, 6'd9,  1'b0, 6'd9,  32'h6,        1'b1, 1'b1};
        tbl[8]  = '{1'b1, 6'd9,  32'h7,        1'b0, 6'd0,  32'h0,  1'b0, 6'd0,  1'b0, 6'd9,  32'h7,        1'b0, 1'b0};
        tbl[9]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,  1'b1, 6'd3,  1'b0, 6'd3,  32'h0,        1'b1, 1'b1};
        tbl[10] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,  1'b1, 6'd4,  1'b0, 6'd4,  32'h0,        1'b1, 1'b1};
        tbl[11] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,  1'b1, 6'd6,  1'b1, 6'd6,  32'h0,        1'b1, 1'b1};
        tbl[12] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,  1'b0, 6'd0,  1'b0, 6'd3,  32'h0,        1'b0, 1'b1};
        tbl[13] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,  1'b0, 6'd0,  1'b0, 6'd4,  32'h0,        1'b0, 1'b1};
        tbl[14] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,  1'b1, 6'd0,  1'b0, 6'd0,  32'h0,        1'b0, 1'b1};
        tbl[15] = '{1'b1, 6'd6,  32'h66,       1'b0, 6'd0,  32'h0,  1'b0, 6'd0,  1'b1, 6'd6,  32'h66,       1'b0, 1'b0};
        tbl[16] = '{1'b1, 6'd13, 32'h13,       1'b0, 6'd0,  32'h0,  1'b1, 6'd12, 1'b0, 6'd13, 32'h13,       1'b0, 1'b1};
        tbl[17] = '{1'b1, 6'h2E, 32'hE,        1'b0, 6'd0,  32'h0,  1'b0, 6'd0,  1'b0, 6'd14, 32'hE,        1'b0, 1'b1};

        rst_n = 1'b0;
        rf_if.raddr_i = '0; rf_if.waddr_i = '0; rf_if.wdata_i = '0; rf_if.rsv_addr_i = '0;
        fp_if.raddr_i = '0; fp_if.waddr_i = '0; fp_if.wdata_i = '0; fp_if.rsv_addr_i = '0;
        zx_if.raddr_i = '0; zx_if.waddr_i = '0; zx_if.wdata_i = '0; zx_if.rsv_addr_i = '0;
        fp_if.we_i = '0; fp_if.rsv_i = 1'b0; fp_if.flush_i = 1'b0;
        zx_if.we_i = '0; zx_if.rsv_i = 1'b0; zx_if.flush_i = 1'b0;
        idle_main();
        set_raddr_all(6'd5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rdata", rf_if.rdata_o[31:0], 32'h0);
        chk("reset_rbusy", 32'(rf_if.rbusy_o), 32'h0);
        chk("reset_busy_any", 32'(rf_if.busy_any_o), 32'h0);
        $display("[TB] reset: rdata=0x%08h rbusy=%b busy_any=%b", rf_if.rdata_o[31:0], rf_if.rbusy_o, rf_if.busy_any_o);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            idle_main();
            if (tbl[i].we0) drive_w(0, tbl[i].wa0, tbl[i].wd0);
            if (tbl[i].we1) drive_w(1, tbl[i].wa1, tbl[i].wd1);
            rf_if.rsv_i      = tbl[i].rsv;
            rf_if.rsv_addr_i = tbl[i].rsv_a;
            rf_if.flush_i    = tbl[i].flush;
            set_raddr_all(tbl[i].rd_a);
            @(posedge clk);
            #1;
            idle_main();
            @(negedge clk);
            $display("[TB] vec %0d: read a=%0d rdata=0x%08h rbusy=%b busy_any=%b", i, tbl[i].rd_a,
                     rf_if.rdata_o[31:0], rf_if.rbusy_o[0], rf_if.busy_any_o);
            chk($sformatf("vec%0d_rdata", i), rf_if.rdata_o[31:0], tbl[i].exp_d);
            chk($sformatf("vec%0d_rbusy", i), 32'(rf_if.rbusy_o[0]), 32'(tbl[i].exp_b));
            chk($sformatf("vec%0d_busy_any", i), 32'(rf_if.busy_any_o), 32'(tbl[i].exp_any));
        end

        // Asynchronous reset in the middle of a cycle with live data and a busy register.
        rf_if.raddr_i[0 +: AW]  = 6'd6;
        rf_if.raddr_i[AW +: AW] = 6'd12;
        #1;
        chk("pre_rst_x6", rf_if.rdata_o[31:0], 32'h66);
        chk("pre_rst_x12_busy", 32'(rf_if.rbusy_o[1]), 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset: x6=0x%08h x12 busy=%b busy_any=%b", rf_if.rdata_o[31:0], rf_if.rbusy_o[1], rf_if.busy_any_o);
        chk("async_rst_x6", rf_if.rdata_o[31:0], 32'h0);
        chk("async_rst_x12_busy", 32'(rf_if.rbusy_o[1]), 32'h0);
        chk("async_rst_busy_any", 32'(rf_if.busy_any_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Same-cycle write while reading a reserved register.
        rf_if.rsv_i = 1'b1; rf_if.rsv_addr_i = 6'd10;
        set_raddr_all(6'd10);
        @(posedge clk);
        #1;
        idle_main();
        @(negedge clk);
        drive_w(0, 6'd10, 32'hA5);
        #1;
        $display("[TB] bypass: x10 rdata=0x%08h rbusy=%b", rf_if.rdata_o[31:0], rf_if.rbusy_o[0]);
`ifdef CV32E41P_RF_BYPASS_EN
        chk("bypass_rdata", rf_if.rdata_o[31:0], 32'hA5);
        chk("bypass_rbusy", 32'(rf_if.rbusy_o[0]), 32'h0);
`else
        chk("nobypass_rdata", rf_if.rdata_o[31:0], 32'h0);
        chk("nobypass_rbusy", 32'(rf_if.rbusy_o[0]), 32'h1);
`endif
        @(posedge clk);
        #1;
        idle_main();
        @(negedge clk);
        chk("after_write_x10", rf_if.rdata_o[31:0], 32'hA5);
        chk("after_write_x10_busy", 32'(rf_if.rbusy_o[0]), 32'h0);

        // FP bank vs ZFINX aliasing.
        fp_if.waddr_i = {6'd0, 6'd32}; fp_if.wdata_i = {32'h1, 32'h3F800000}; fp_if.we_i = 2'b11;
        zx_if.waddr_i = {6'd33, 6'd32}; zx_if.wdata_i = {32'h12, 32'h3F800000}; zx_if.we_i = 2'b11;
        @(posedge clk);
        #1;
        fp_if.we_i = '0; zx_if.we_i = '0;
        fp_if.raddr_i = {6'd1, 6'd0, 6'd32};
        zx_if.raddr_i = {6'd1, 6'd0, 6'd32};
        fp_if.rsv_i = 1'b1; fp_if.rsv_addr_i = 6'd32;
        @(negedge clk);
        $display("[TB] fp: f0=0x%08h x0=0x%08h | zfinx: a32=0x%08h x1=0x%08h",
                 fp_if.rdata_o[31:0], fp_if.rdata_o[63:32], zx_if.rdata_o[31:0], zx_if.rdata_o[95:64]);
        chk("fp_f0", fp_if.rdata_o[31:0], 32'h3F800000);
        chk("fp_x0", fp_if.rdata_o[63:32], 32'h0);
        chk("fp_x1", fp_if.rdata_o[95:64], 32'h0);
        chk("zx_a32", zx_if.rdata_o[31:0], 32'h0);
        chk("zx_x0", zx_if.rdata_o[63:32], 32'h0);
        chk("zx_x1_alias", zx_if.rdata_o[95:64], 32'h12);
        @(posedge clk);
        #1;
        fp_if.rsv_i = 1'b0;
        @(negedge clk);
        chk("fp_f0_busy", 32'(fp_if.rbusy_o[0]), 32'h1);
        chk("fp_x0_busy", 32'(fp_if.rbusy_o[1]), 32'h0);

        // Randomized traffic against the reference model, starting from a clean reset.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        for (int c = 0; c < 200; c++) begin
            logic [31:0] exp_d;
            logic        exp_b;
            logic        exp_any;
            logic        wr_hit [32];
            logic        nb;
            idle_main();
            for (int p = 0; p < NW; p++) begin
                logic [5:0] a;
                a = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
                rf_if.waddr_i[p*AW +: AW] = a;
                rf_if.wdata_i[p*DW +: DW] = $urandom;
                rf_if.we_i[p]             = ($urandom_range(0, 1) == 1);
            end
            rf_if.rsv_i      = ($urandom_range(0, 2) == 0);
            rf_if.rsv_addr_i = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
            rf_if.flush_i    = ($urandom_range(0, 15) == 0);
            for (int r = 0; r < NR; r++)
                rf_if.raddr_i[r*AW +: AW] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
            #1;
            exp_any = 1'b0;
            for (int i = 0; i < 32; i++) exp_any = exp_any | m_busy[i];
            for (int r = 0; r < NR; r++) begin
                int ra;
                ra    = int'(rf_if.raddr_i[r*AW +: 5]);
                exp_d = m_reg[ra];
                exp_b = m_busy[ra];
`ifdef CV32E41P_RF_BYPASS_EN
                for (int p = 0; p < NW; p++) begin
                    if (rf_if.we_i[p] && (int'(rf_if.waddr_i[p*AW +: 5]) == ra) && (ra != 0)) begin
                        exp_d = rf_if.wdata_i[p*DW +: DW];
                        exp_b = 1'b0;
                    end
                end
`endif
                chk($sformatf("rnd%0d_rdata%0d", c, r), rf_if.rdata_o[r*DW +: DW], exp_d);
                chk($sformatf("rnd%0d_rbusy%0d", c, r), 32'(rf_if.rbusy_o[r]), 32'(exp_b));
            end
            chk($sformatf("rnd%0d_busy_any", c), 32'(rf_if.busy_any_o), 32'(exp_any));
            $display("[TB] rnd %0d: we=%b waddr=%h rsv=%b@%0d flush=%b raddr=%h rdata0=0x%08h busy_any=%b",
                     c, rf_if.we_i, rf_if.waddr_i, rf_if.rsv_i, rf_if.rsv_addr_i, rf_if.flush_i,
                     rf_if.raddr_i, rf_if.rdata_o[31:0], rf_if.busy_any_o);
            @(posedge clk);
            for (int i = 0; i < 32; i++) wr_hit[i] = 1'b0;
            for (int p = 0; p < NW; p++) begin
                if (rf_if.we_i[p]) begin
                    int wa;
                    wa         = int'(rf_if.waddr_i[p*AW +: 5]);
                    wr_hit[wa] = 1'b1;
                    if (wa != 0) m_reg[wa] = rf_if.wdata_i[p*DW +: DW];
                end
            end
            for (int i = 1; i < 32; i++) begin
                nb = m_busy[i];
                if (rf_if.rsv_i && (int'(rf_if.rsv_addr_i[4:0]) == i)) nb = 1'b1;
                else if (rf_if.flush_i || wr_hit[i])                   nb = 1'b0;
                m_busy[i] = nb;
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
